// File: rtl/exception_vector_fetch_pkg.sv
// Shared definitions for the exception vector fetch block: FSM state
// encoding, cause codes, vector addresses and the EPC return-address offset.
package exception_vector_fetch_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CAUSE_W = 2;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAVE    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_LOAD    = 3'd4
  } state_e;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE     = 2'b00;
  localparam logic [CAUSE_W-1:0] CAUSE_OPCODE   = 2'b01;
  localparam logic [CAUSE_W-1:0] CAUSE_OVERFLOW = 2'b10;
  localparam logic [CAUSE_W-1:0] CAUSE_DIVZERO  = 2'b11;

  localparam logic [ADDR_W-1:0] VEC_OPCODE   = 32'd253;
  localparam logic [ADDR_W-1:0] VEC_OVERFLOW = 32'd254;
  localparam logic [ADDR_W-1:0] VEC_DIVZERO  = 32'd255;

  // pc_current points past the faulting instruction; EPC gets it minus 4.
  localparam logic [ADDR_W-1:0] PC_OFFSET = 32'd4;

  // Map a latched cause to the byte address holding its handler vector.
  function automatic logic [ADDR_W-1:0] vector_of(input logic [CAUSE_W-1:0] c);
    logic [ADDR_W-1:0] v;
    case (c)
      CAUSE_OPCODE:   v = VEC_OPCODE;
      CAUSE_OVERFLOW: v = VEC_OVERFLOW;
      CAUSE_DIVZERO:  v = VEC_DIVZERO;
      default:        v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/exception_vector_fetch_wait_counter.sv
// 3-bit down-counter pacing the memory wait cycles.
// Ports: clk, rst_n (async active-low), load/load_val (preset),
//        en (decrement, saturates at 0), zero_c (count is zero).
module exception_vector_fetch_wait_counter
  import exception_vector_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero_c
);

  logic [CNT_W-1:0] count_q, count_d;

  // Load has priority over decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/exception_vector_fetch.sv
// Exception entry sequencer: latches the highest-priority exception request,
// writes EPC, fetches the handler vector byte from memory and strobes a PC load.
// Ports: clk, reset (async active-low); ex_opcode/ex_overflow/ex_divzero
//        (level requests); pc_current; mem_data (read byte); mem_addr/mem_rd
//        (vector read); epc_value/epc_write; mda (vector byte); pc_load;
//        cause (latched cause); busy (stall control unit).
module exception_vector_fetch
  import exception_vector_fetch_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_opcode,
  input  logic                ex_overflow,
  input  logic                ex_divzero,
  input  logic [ADDR_W-1:0]   pc_current,
  input  logic [DATA_W-1:0]   mem_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   epc_value,
  output logic                epc_write,
  output logic [DATA_W-1:0]   mda,
  output logic                pc_load,
  output logic [CAUSE_W-1:0]  cause,
  output logic                busy
);

  // WAIT lasts MEM_LAT-1 cycles: counter preset to MEM_LAT-2, exit on zero.
  localparam bit          HAS_WAIT  = (MEM_LAT > 1);
  localparam int unsigned WAIT_INIT = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;

  state_e              state_q, state_d;
  logic [CAUSE_W-1:0]  cause_q, cause_d;
  logic [ADDR_W-1:0]   pc_lat_q, pc_lat_d;
  logic [DATA_W-1:0]   mda_q, mda_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   epc_value_q, epc_value_d;
  logic                epc_write_q, epc_write_d;
  logic                pc_load_q, pc_load_d;
  logic                busy_q, busy_d;
  logic                cnt_load, cnt_en, cnt_zero_c;

  exception_vector_fetch_wait_counter u_wait_counter (
    .clk      (clk),
    .rst_n    (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(WAIT_INIT)),
    .en       (cnt_en),
    .zero_c   (cnt_zero_c)
  );

  // Next-state logic; outputs are decoded from the next state so they are
  // registered yet line up with the state they belong to.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    pc_lat_d = pc_lat_q;
    mda_d    = mda_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ex_opcode || ex_overflow || ex_divzero) begin
          state_d  = ST_SAVE;
          pc_lat_d = pc_current;
          if (ex_opcode)        cause_d = CAUSE_OPCODE;
          else if (ex_overflow) cause_d = CAUSE_OVERFLOW;
          else                  cause_d = CAUSE_DIVZERO;
        end
      end
      ST_SAVE: begin
        if (HAS_WAIT) begin
          state_d  = ST_WAIT;
          cnt_load = 1'b1;
        end else begin
          state_d  = ST_CAPTURE;
        end
      end
      ST_WAIT: begin
        if (cnt_zero_c) state_d = ST_CAPTURE;
        else            cnt_en  = 1'b1;
      end
      ST_CAPTURE: begin
        mda_d   = mem_data;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_rd_d    = (state_d == ST_SAVE) || (state_d == ST_WAIT) ||
                  (state_d == ST_CAPTURE);
    mem_addr_d  = mem_rd_d ? vector_of(cause_d) : '0;
    epc_write_d = (state_d == ST_SAVE);
    epc_value_d = epc_write_d ? (pc_lat_d - PC_OFFSET) : '0;
    pc_load_d   = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cause_q     <= CAUSE_NONE;
      pc_lat_q    <= '0;
      mda_q       <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      epc_value_q <= '0;
      epc_write_q <= 1'b0;
      pc_load_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      pc_lat_q    <= pc_lat_d;
      mda_q       <= mda_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      epc_value_q <= epc_value_d;
      epc_write_q <= epc_write_d;
      pc_load_q   <= pc_load_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign epc_value = epc_value_q;
  assign epc_write = epc_write_q;
  assign mda       = mda_q;
  assign pc_load   = pc_load_q;
  assign cause     = cause_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_exception_vector_fetch.sv
// Bench for exception_vector_fetch: two instances (MEM_LAT=2 and MEM_LAT=1)
// share stimulus; a cycle-offset model predicts every output each cycle.
module tb_exception_vector_fetch;

  logic        clk;
  logic        reset;
  logic        ex_opcode, ex_overflow, ex_divzero;
  logic [31:0] pc_current;
  logic [7:0]  mem_data  [2];
  logic [31:0] mem_addr  [2];
  logic        mem_rd    [2];
  logic [31:0] epc_value [2];
  logic        epc_write [2];
  logic [7:0]  mda       [2];
  logic        pc_load   [2];
  logic [1:0]  cause     [2];
  logic        busy      [2];

  int n_pass  = 0;
  int n_total = 0;

  exception_vector_fetch #(.MEM_LAT(2)) u_dut0 (
    .clk(clk), .reset(reset), .ex_opcode(ex_opcode), .ex_overflow(ex_overflow),
    .ex_divzero(ex_divzero), .pc_current(pc_current), .mem_data(mem_data[0]),
    .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]), .epc_value(epc_value[0]),
    .epc_write(epc_write[0]), .mda(mda[0]), .pc_load(pc_load[0]),
    .cause(cause[0]), .busy(busy[0]));

  exception_vector_fetch #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .ex_opcode(ex_opcode), .ex_overflow(ex_overflow),
    .ex_divzero(ex_divzero), .pc_current(pc_current), .mem_data(mem_data[1]),
    .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]), .epc_value(epc_value[1]),
    .epc_write(epc_write[1]), .mda(mda[1]), .pc_load(pc_load[1]),
    .cause(cause[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Memory: a read issued in cycle n returns mem[addr] in cycle n+latency.
  logic [7:0]  mem  [256];
  logic [32:0] hist [2][8];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 7; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = {mem_rd[i], mem_addr[i]};
    end
  end

  always @(posedge clk) begin
    logic [32:0] e;
    #1;
    for (int i = 0; i < 2; i++) begin
      e = hist[i][lat_of(i) - 1];
      if (e[32] && (e[31:8] == 24'd0)) mem_data[i] = mem[e[7:0]];
      else                             mem_data[i] = 8'($urandom);
    end
  end

  // Model: a sequence is tracked as the cycle offset t since the request edge.
  // t=1 SAVE, t=2..L WAIT, t=L+1 CAPTURE, t=L+2 LOAD.
  bit          m_active [2];
  int          m_t      [2];
  logic [1:0]  m_cause  [2];
  logic [31:0] m_pc     [2];
  logic [7:0]  m_mda    [2];

  always @(posedge clk or negedge reset) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_active[i] = 0; m_t[i] = 0; m_cause[i] = 2'd0; m_pc[i] = 32'd0; m_mda[i] = 8'd0;
      end else if (m_active[i]) begin
        if (m_t[i] == lat_of(i) + 1) m_mda[i] = mem[8'(252 + int'(m_cause[i]))];
        if (m_t[i] == lat_of(i) + 2) begin m_active[i] = 0; m_t[i] = 0; end
        else m_t[i] = m_t[i] + 1;
      end else if (ex_opcode || ex_overflow || ex_divzero) begin
        m_active[i] = 1;
        m_t[i]      = 1;
        m_pc[i]     = pc_current;
        m_cause[i]  = ex_opcode ? 2'd1 : (ex_overflow ? 2'd2 : 2'd3);
      end
    end
  end

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] @%0t: got 0x%08h, expected 0x%08h", name, inst, $time, act, exp);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit          a, e_rd;
      int          t, l;
      a = m_active[i]; t = m_t[i]; l = lat_of(i);
      e_rd = a && (t >= 1) && (t <= l + 1);
      check("busy",      i, 32'(busy[i]),      32'(a));
      check("epc_write", i, 32'(epc_write[i]), 32'(a && t == 1));
      check("epc_value", i, epc_value[i],      (a && t == 1) ? m_pc[i] - 32'd4 : 32'd0);
      check("mem_rd",    i, 32'(mem_rd[i]),    32'(e_rd));
      check("mem_addr",  i, mem_addr[i],       e_rd ? 32'(252 + int'(m_cause[i])) : 32'd0);
      check("pc_load",   i, 32'(pc_load[i]),   32'(a && t == l + 2));
      check("mda",       i, 32'(mda[i]),       32'(m_mda[i]));
      check("cause",     i, 32'(cause[i]),     32'(m_cause[i]));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Wait (bounded) until both instances are idle, then align to posedge+1.
  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (!busy[0] && !busy[1]) ok = 1;
    end
    if (!ok) begin n_total++; $display("FAIL wait_idle: busy did not drop within 50 cycles"); end
    step();
  endtask

  // Observe 7 cycles of one instance starting in cycle 1; mask drives ex_divzero.
  task automatic observe(input int inst, input logic [7:0] mask, output int n_pl,
                         output int pl_cyc, output int n_busy, output logic [31:0] epcv1,
                         output logic [31:0] addr1, output logic [1:0] cause1);
    n_pl = 0; pl_cyc = 0; n_busy = 0; epcv1 = 0; addr1 = 0; cause1 = 0;
    for (int c = 1; c <= 7; c++) begin
      ex_divzero = mask[c];
      @(negedge clk);
      if (c == 1) begin epcv1 = epc_value[inst]; addr1 = mem_addr[inst]; cause1 = cause[inst]; end
      if (pc_load[inst]) begin n_pl++; if (pl_cyc == 0) pl_cyc = c; end
      if (busy[inst]) n_busy++;
      step();
    end
    ex_divzero = 1'b0;
  endtask

  int          n_pl, pl_cyc, n_busy;
  logic [31:0] epcv1, addr1;
  logic [1:0]  cause1;

  initial begin
    reset = 1'b0; ex_opcode = 0; ex_overflow = 0; ex_divzero = 0; pc_current = 0;
    for (int j = 0; j < 256; j++) mem[j] = 8'($urandom);
    mem[253] = 8'h7F; mem[254] = 8'h81; mem[255] = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 0, 32'(busy[0]), 32'd0);
    check("rst_mda", 0, 32'(mda[0]), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Overflow at pc 0x40, latency 2
    pc_current = 32'h40; ex_overflow = 1; step(); ex_overflow = 0;
    observe(0, 8'h00, n_pl, pl_cyc, n_busy, epcv1, addr1, cause1);
    check("ovf_epc", 0, epcv1, 32'h3C);
    check("ovf_addr", 0, addr1, 32'd254);
    check("ovf_pl_cycle", 0, 32'(pl_cyc), 32'd4);
    check("ovf_pl_count", 0, 32'(n_pl), 32'd1);
    check("ovf_mda", 0, 32'(mda[0]), 32'h81);

    // Opcode, latency 1: no WAIT
    wait_idle();
    pc_current = 32'h100; ex_opcode = 1; step(); ex_opcode = 0;
    observe(1, 8'h00, n_pl, pl_cyc, n_busy, epcv1, addr1, cause1);
    check("lat1_pl_cycle", 1, 32'(pl_cyc), 32'd3);
    check("lat1_busy_cycles", 1, 32'(n_busy), 32'd3);
    check("lat1_mda", 1, 32'(mda[1]), 32'h7F);

    // All three requests together
    wait_idle();
    pc_current = 32'h1234; ex_opcode = 1; ex_overflow = 1; ex_divzero = 1; step();
    ex_opcode = 0; ex_overflow = 0; ex_divzero = 0;
    observe(0, 8'h00, n_pl, pl_cyc, n_busy, epcv1, addr1, cause1);
    check("all3_cause", 0, 32'(cause1), 32'd1);
    check("all3_addr", 0, addr1, 32'd253);
    check("all3_pl_count", 0, 32'(n_pl), 32'd1);

    // Divzero re-pulsed during WAIT (cycle 2) and LOAD (cycle 4)
    wait_idle();
    pc_current = 32'h80; ex_overflow = 1; step(); ex_overflow = 0;
    observe(0, 8'b0001_0100, n_pl, pl_cyc, n_busy, epcv1, addr1, cause1);
    check("repulse_pl_count", 0, 32'(n_pl), 32'd1);
    check("repulse_pl_cycle", 0, 32'(pl_cyc), 32'd4);
    check("repulse_busy_cycles", 0, 32'(n_busy), 32'd4);
    check("repulse_cause", 0, 32'(cause[0]), 32'd2);

    // PC wrap-around
    wait_idle();
    pc_current = 32'h0; ex_divzero = 1; step(); ex_divzero = 0;
    observe(0, 8'h00, n_pl, pl_cyc, n_busy, epcv1, addr1, cause1);
    check("wrap_epc", 0, epcv1, 32'hFFFF_FFFC);
    check("wrap_mda", 0, 32'(mda[0]), 32'hA5);

    // Reset during CAPTURE (cycle 3 for latency 2)
    wait_idle();
    pc_current = 32'h200; ex_overflow = 1; step(); ex_overflow = 0;
    step(); step();
    #2; reset = 1'b0; #1;
    check("rstcap_busy", 0, 32'(busy[0]), 32'd0);
    check("rstcap_mem_rd", 0, 32'(mem_rd[0]), 32'd0);
    check("rstcap_mem_addr", 0, mem_addr[0], 32'd0);
    check("rstcap_mda", 0, 32'(mda[0]), 32'd0);
    check("rstcap_cause", 0, 32'(cause[0]), 32'd0);
    @(posedge clk); #1; reset = 1'b1;
    observe(0, 8'h00, n_pl, pl_cyc, n_busy, epcv1, addr1, cause1);
    check("rstcap_no_pl", 0, 32'(n_pl), 32'd0);
    check("rstcap_idle", 0, 32'(n_busy), 32'd0);

    // Randomized level requests with occasional resets
    for (int j = 253; j < 256; j++) mem[j] = 8'($urandom);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        ex_opcode   = ($urandom_range(0, 5) == 0);
        ex_overflow = ($urandom_range(0, 5) == 0);
        ex_divzero  = ($urandom_range(0, 5) == 0);
      end
      pc_current = $urandom;
      reset = ($urandom_range(0, 199) != 0);
      step();
    end
    reset = 1'b1; ex_opcode = 0; ex_overflow = 0; ex_divzero = 0;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exception_vector_fetch.md
EXCEPTION_VECTOR_FETCH -- requirements
Module: exception_vector_fetch

Interface
REQ-001 Parameter MEM_LAT, default 2: memory read latency in cycles, legal range 1..7.
REQ-002 Port clk, input, 1: single system clock, rising-edge active.
REQ-003 Port reset, input, 1: asynchronous, active-low reset.
REQ-004 Port ex_opcode, input, 1: invalid-opcode exception request, level.
REQ-005 Port ex_overflow, input, 1: ALU overflow exception request, level.
REQ-006 Port ex_divzero, input, 1: divide-by-zero exception request, level.
REQ-007 Port pc_current, input, 32: PC of the instruction following the faulting one.
REQ-008 Port mem_data, input, 8: byte lane of memory read data.
REQ-009 Port mem_addr, output, 32: memory address driven during vector fetch.
REQ-010 Port mem_rd, output, 1: memory read enable.
REQ-011 Port epc_value, output, 32: value to write into EPC.
REQ-012 Port epc_write, output, 1: one-cycle EPC write strobe.
REQ-013 Port mda, output, 8: registered vector byte, fed to the 8-to-32 sign extender.
REQ-014 Port pc_load, output, 1: one-cycle strobe; PC loads the sign-extended mda.
REQ-015 Port cause, output, 2: latched cause, 00 none, 01 opcode, 10 overflow, 11 divzero.
REQ-016 Port busy, output, 1: high in every non-IDLE state; control unit stalls on it.

Function
REQ-017 FSM states: IDLE, SAVE, WAIT, CAPTURE, LOAD.
REQ-018 IDLE: any request high at a rising edge -> SAVE; latch cause and pc_current.
REQ-019 Priority on simultaneous requests: opcode > overflow > divzero; lower ones dropped.
REQ-020 SAVE (1 cycle): epc_write=1, epc_value=latched PC minus 4 (mod 2^32), mem_rd=1, mem_addr=vector.
REQ-021 Vectors: opcode 32'd253, overflow 32'd254, divzero 32'd255.
REQ-022 WAIT: exactly MEM_LAT-1 cycles counted by the wait counter; mem_rd=1, mem_addr held; MEM_LAT=1 skips WAIT.
REQ-023 CAPTURE (1 cycle): mem_rd=1, mem_addr held; mda <= mem_data at the closing edge.
REQ-024 LOAD (1 cycle): pc_load=1, mem_rd=0; then -> IDLE.
REQ-025 Latency: request seen at edge of cycle 0 -> epc_write in cycle 1 -> pc_load in cycle 2+MEM_LAT.
REQ-026 Requests arriving while busy=1, including during LOAD, are ignored; no queuing.
REQ-027 A request still held high on return to IDLE starts a new sequence (level-sensitive).
REQ-028 mda and cause hold their values in IDLE until the next CAPTURE and SAVE respectively.
REQ-029 epc_value is driven only in SAVE and is 0 otherwise; mem_addr is 0 when mem_rd=0.
REQ-030 Strobes epc_write and pc_load never exceed one cycle per sequence.

Reset
REQ-031 Reset low: state=IDLE, counter=0, mda=0, cause=00, latched PC=0, all outputs 0, effective immediately.
REQ-032 Reset mid-sequence aborts it; no epc_write or pc_load is issued after reset deasserts until a new request.

Structure
REQ-033 Shared package holds state encoding, cause codes, the three vector addresses and the PC offset of 4.
REQ-034 One sub-module is used: wait_counter (3-bit down-counter, load/enable, zero flag).

Verification
REQ-035 Overflow with pc_current=0x00000040, MEM_LAT=2, mem_data=0x81 at 254 -> epc_value=0x3C in cycle 1, mda=0x81, pc_load in cycle 4.
REQ-036 All three requests asserted in the same cycle -> cause=01, mem_addr=253, exactly one sequence.
REQ-037 Divzero re-pulsed in the WAIT and LOAD cycles -> ignored, busy timeline unchanged, single pc_load.
REQ-038 Reset asserted in CAPTURE -> outputs 0 immediately, mda=0, no pc_load after release.
REQ-039 MEM_LAT=1, opcode request, mem_data=0x7F -> pc_load in cycle 3, mda=0x7F, no WAIT state.
REQ-040 pc_current=0x00000000 -> epc_value=0xFFFFFFFC (wrap-around).
